// File: rtl/arbitro_vc_sched.sv
// Two-VC read scheduler for the PCIe transmit path: pops VC0/VC1, covers the
// one-cycle FIFO read latency and forwards each word to D0/D1 by its MSB.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | both VC FIFOs empty, nothing to pop
// ACTIVE | at least one VC non-empty and both destinations have room
// STALL  | a destination is almost full; in-flight words still drain
module arbitro_vc_sched #(
    parameter int DATA_W     = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              VC0_empty,
    input  logic              VC1_empty,
    input  logic [DATA_W-1:0] VC0_data,
    input  logic [DATA_W-1:0] VC1_data,
    input  logic              D0_almost_full,
    input  logic              D1_almost_full,
    output logic              pop_VC0,
    output logic              pop_VC1,
    output logic              push_D0,
    output logic              push_D1,
    output logic [DATA_W-1:0] data_out,
    output logic              grant_vc,
    output logic              idle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_vc_q, s1_vc_d;
    logic [2:0]        starve_q, starve_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              push_d0_q, push_d0_d;
    logic              push_d1_q, push_d1_d;
    logic              grant_q, grant_d;

    logic              any_af;
    logic              force_vc1;
    logic              pop0;
    logic              pop1;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        state_d    = state_q;
        pop0       = 1'b0;
        pop1       = 1'b0;
        starve_d   = starve_q;
        s1_valid_d = 1'b0;
        s1_vc_d    = s1_vc_q;
        data_out_d = data_out_q;
        push_d0_d  = 1'b0;
        push_d1_d  = 1'b0;
        grant_d    = grant_q;
        rd_word    = VC0_data;

        any_af    = D0_almost_full | D1_almost_full;
        force_vc1 = (starve_q == STARVE_LIM) && !VC1_empty;

        if (any_af) begin
            state_d = ST_STALL;
        end else if (VC0_empty && VC1_empty) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_ACTIVE;
        end

        // The state is evaluated this cycle so a rising almost_full blocks
        // the pop in the same cycle; the destination is unknown until the
        // word returns, so either flag gates both VCs.
        if (!reset && state_d == ST_ACTIVE) begin
            if (!VC0_empty && !force_vc1) begin
                pop0 = 1'b1;
            end else begin
                pop1 = 1'b1;
            end
        end

        if (VC1_empty || pop1) begin
            starve_d = 3'd0;
        end else if (pop0 && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 3'd1;
        end

        s1_valid_d = pop0 | pop1;
        if (pop0 | pop1) begin
            s1_vc_d = pop1;
        end

        // FIFO read data is valid one cycle after the pop.
        if (s1_valid_q) begin
            rd_word    = s1_vc_q ? VC1_data : VC0_data;
            data_out_d = rd_word;
            push_d1_d  = rd_word[DATA_W-1];
            push_d0_d  = !rd_word[DATA_W-1];
            grant_d    = s1_vc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_vc_q    <= 1'b0;
            starve_q   <= 3'd0;
            data_out_q <= '0;
            push_d0_q  <= 1'b0;
            push_d1_q  <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_vc_q    <= s1_vc_d;
            starve_q   <= starve_d;
            data_out_q <= data_out_d;
            push_d0_q  <= push_d0_d;
            push_d1_q  <= push_d1_d;
            grant_q    <= grant_d;
        end
    end

    assign pop_VC0  = pop0;
    assign pop_VC1  = pop1;
    assign push_D0  = push_d0_q;
    assign push_D1  = push_d1_q;
    assign data_out = data_out_q;
    assign grant_vc = grant_q;
    // The push flops double as the second pipeline valid bit.
    assign idle     = (state_q == ST_IDLE) && !s1_valid_q && !push_d0_q && !push_d1_q;

endmodule

// File: tb/tb_arbitro_vc_sched.sv
// Bench for arbitro_vc_sched: queue-based VC FIFO models and a transaction-level
// scheduling model predict pops, pushes, data_out, grant_vc and idle.
module tb_arbitro_vc_sched;

    localparam int DW   = 6;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          VC0_empty = 1'b1;
    logic          VC1_empty = 1'b1;
    logic [DW-1:0] VC0_data = '0;
    logic [DW-1:0] VC1_data = '0;
    logic          D0_almost_full = 1'b0;
    logic          D1_almost_full = 1'b0;
    logic          pop_VC0, pop_VC1, push_D0, push_D1, grant_vc, idle;
    logic [DW-1:0] data_out;

    arbitro_vc_sched #(.DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .VC0_data(VC0_data), .VC1_data(VC1_data),
        .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
        .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
        .push_D0(push_D0), .push_D1(push_D1),
        .data_out(data_out), .grant_vc(grant_vc), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] w;
        logic          vc;
    } ent_t;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    ent_t          sched[$];
    int            glog[$];

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            starve = 0;
    bit            out_known = 0;
    logic          exp_p0, exp_p1, exp_push0, exp_push1, exp_grant, exp_idle;
    logic [DW-1:0] exp_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock: drive FIFO flags, check at negedge, then advance the model.
    task automatic step();
        bit            e0, e1;
        ent_t          e;
        logic [DW-1:0] w;
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        VC0_empty = e0;
        VC1_empty = e1;
        @(negedge clk);
        exp_p0 = 1'b0;
        exp_p1 = 1'b0;
        if (!reset && !D0_almost_full && !D1_almost_full) begin
            if (!e0 && !(starve == SMAX && !e1)) exp_p0 = 1'b1;
            else if (!e1)                        exp_p1 = 1'b1;
        end
        chk("pop_vc0", 32'(pop_VC0), 32'(exp_p0));
        chk("pop_vc1", 32'(pop_VC1), 32'(exp_p1));
        if (out_known) begin
            exp_push0 = 1'b0;
            exp_push1 = 1'b0;
            if (sched.size() > 0 && sched[0].due == cyc) begin
                e = sched.pop_front();
                exp_push0 = !e.w[DW-1];
                exp_push1 = e.w[DW-1];
                exp_dout  = e.w;
                exp_grant = e.vc;
            end
            chk("push_d0", 32'(push_D0), 32'(exp_push0));
            chk("push_d1", 32'(push_D1), 32'(exp_push1));
            chk("data_out", 32'(data_out), 32'(exp_dout));
            chk("grant_vc", 32'(grant_vc), 32'(exp_grant));
            chk("idle", 32'(idle), 32'(exp_idle));
        end
        @(posedge clk);
        #1;
        VC0_data = DW'($urandom);
        VC1_data = DW'($urandom);
        if (reset) begin
            sched.delete();
            starve    = 0;
            exp_dout  = '0;
            exp_grant = 1'b0;
            exp_idle  = 1'b1;
            out_known = 1;
        end else begin
            if (exp_p0) begin
                w = q0.pop_front();
                VC0_data = w;
                e.due = cyc + 2; e.w = w; e.vc = 1'b0;
                sched.push_back(e);
                glog.push_back(0);
            end
            if (exp_p1) begin
                w = q1.pop_front();
                VC1_data = w;
                e.due = cyc + 2; e.w = w; e.vc = 1'b1;
                sched.push_back(e);
                glog.push_back(1);
            end
            if (e1 || exp_p1)                 starve = 0;
            else if (exp_p0 && starve < SMAX) starve++;
            exp_idle = !D0_almost_full && !D1_almost_full && e0 && e1 && (sched.size() == 0);
        end
        cyc++;
    endtask

    initial begin
        int n;

        // Reset held two cycles with VC0 non-empty, then first pop at once.
        reset = 1'b1;
        q0.push_back(6'h05);
        step();
        step();
        reset = 1'b0;
        step();
        chk("first_pop_after_reset", 32'(glog.size()), 32'd1);
        repeat (4) step();

        // Back-to-back VC0 words to D0 then D1.
        q0.push_back(6'h05);
        q0.push_back(6'h25);
        repeat (6) step();

        // Starvation guard: six VC0 words with one VC1 word pending.
        glog.delete();
        for (int i = 0; i < 6; i++) q0.push_back(6'(i + 1));
        q1.push_back(6'h11);
        repeat (10) step();
        chk("starve_order_len", 32'(glog.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            chk("starve_order", 32'(glog[i]), (i == 4) ? 32'd1 : 32'd0);

        // D1 almost full for three cycles mid-stream.
        for (int i = 0; i < 8; i++) q0.push_back(6'($urandom));
        repeat (2) step();
        D1_almost_full = 1'b1;
        n = glog.size();
        repeat (3) step();
        chk("af_no_pop", 32'(glog.size()), 32'(n));
        D1_almost_full = 1'b0;
        step();
        chk("af_resume", 32'(glog.size()), 32'(n + 1));
        repeat (10) step();

        // Lone VC1 word.
        q1.push_back(6'h3F);
        repeat (5) step();

        // VC1 toggling empty during a VC0 burst.
        for (int i = 0; i < 12; i++) q0.push_back(6'($urandom));
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) q1.push_back(6'($urandom));
            step();
        end
        repeat (8) step();

        // Reset with words in flight.
        for (int i = 0; i < 3; i++) q0.push_back(6'($urandom));
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();

        // Randomized traffic, backpressure and occasional reset.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) q0.push_back(6'($urandom));
            if ($urandom_range(0, 4) == 0) q1.push_back(6'($urandom));
            D0_almost_full = ($urandom_range(0, 9) == 0);
            D1_almost_full = ($urandom_range(0, 9) == 0);
            reset          = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        D0_almost_full = 1'b0;
        D1_almost_full = 1'b0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
